// File: rtl/aes_round_sequencer_if.sv
// Host/datapath control bundle for the iterative AES round sequencer.
// The master drives the block request; the slave (sequencer) drives status and datapath strobes.
interface aes_round_sequencer_if #(
  parameter int unsigned KLEN_W = 8,
  parameter int unsigned WIDX_W = 6
);
  logic              start;
  logic              new_key;
  logic [KLEN_W-1:0] key_len;
  logic              abort;
  logic              ready;
  logic              busy;
  logic              done;
  logic              err;
  logic              kexp_en;
  logic [WIDX_W-1:0] kexp_idx;
  logic              kexp_rot;
  logic              kexp_sub;
  logic              ark_load;
  logic              round_en;
  logic              final_round;
  logic [3:0]        round_idx;

  modport master (
    output start, new_key, key_len, abort,
    input  ready, busy, done, err, kexp_en, kexp_idx, kexp_rot, kexp_sub,
           ark_load, round_en, final_round, round_idx
  );

  modport slave (
    input  start, new_key, key_len, abort,
    output ready, busy, done, err, kexp_en, kexp_idx, kexp_rot, kexp_sub,
           ark_load, round_en, final_round, round_idx
  );
endinterface

// File: rtl/aes_round_sequencer.sv
// Sequences one shared AES round unit over Nr rounds and its word-serial key expander,
// caching the expanded key so repeated blocks under the same key skip expansion.
module aes_round_sequencer #(
  parameter int unsigned KLEN_W = 8,
  parameter int unsigned WIDX_W = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  aes_round_sequencer_if.slave  bus
);

  localparam int unsigned NK_W   = 4;
  localparam int unsigned RIDX_W = 4;
  localparam int unsigned WMOD_W = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEY_EXP,
    S_INIT,
    S_ROUND,
    S_FINAL,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [NK_W-1:0]     nk_q, nk_d;
  logic [RIDX_W-1:0]   nr_q, nr_d;
  logic [WMOD_W-1:0]   wmod_q, wmod_d;
  logic                cache_vld_q, cache_vld_d;
  logic [NK_W-1:0]     cache_nk_q, cache_nk_d;

  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                kexp_en_q, kexp_en_d;
  logic [WIDX_W-1:0]   kexp_idx_q, kexp_idx_d;
  logic                kexp_rot_q, kexp_rot_d;
  logic                kexp_sub_q, kexp_sub_d;
  logic                ark_load_q, ark_load_d;
  logic                round_en_q, round_en_d;
  logic                final_round_q, final_round_d;
  logic [RIDX_W-1:0]   round_idx_q, round_idx_d;

  logic                dec_legal;
  logic [NK_W-1:0]     dec_nk;
  logic [RIDX_W-1:0]   dec_nr;
  logic [WIDX_W-1:0]   last_widx;
  logic                wmod_wrap;

  // Key-length byte to (Nk, Nr)
  always_comb begin
    dec_legal = 1'b1;
    dec_nk    = '0;
    dec_nr    = '0;
    case (bus.key_len)
      KLEN_W'(16): begin dec_nk = NK_W'(4); dec_nr = RIDX_W'(10); end
      KLEN_W'(24): begin dec_nk = NK_W'(6); dec_nr = RIDX_W'(12); end
      KLEN_W'(32): begin dec_nk = NK_W'(8); dec_nr = RIDX_W'(14); end
      default:     dec_legal = 1'b0;
    endcase
  end

  // Last expanded word is 4*(Nr+1)-1; wmod tracks kexp_idx mod Nk without a divider
  assign last_widx = WIDX_W'({nr_q, 2'b11});
  assign wmod_wrap = (wmod_q == WMOD_W'(nk_q - NK_W'(1)));

  always_comb begin
    state_d     = state_q;
    nk_d        = nk_q;
    nr_d        = nr_q;
    wmod_d      = wmod_q;
    cache_vld_d = cache_vld_q;
    cache_nk_d  = cache_nk_q;
    kexp_idx_d  = '0;
    round_idx_d = '0;
    err_d       = 1'b0;

    if (bus.abort) begin
      state_d = S_IDLE;
      // A partially rewritten key store is no longer usable
      if (state_q == S_KEY_EXP) cache_vld_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            if (!dec_legal) begin
              err_d = 1'b1;
            end else begin
              nk_d = dec_nk;
              nr_d = dec_nr;
              if (bus.new_key || !cache_vld_q || (dec_nk != cache_nk_q)) begin
                state_d    = S_KEY_EXP;
                kexp_idx_d = WIDX_W'(dec_nk);
                wmod_d     = '0;
              end else begin
                state_d = S_INIT;
              end
            end
          end
        end
        S_KEY_EXP: begin
          if (kexp_idx_q == last_widx) begin
            cache_vld_d = 1'b1;
            cache_nk_d  = nk_q;
            state_d     = S_INIT;
          end else begin
            kexp_idx_d = kexp_idx_q + WIDX_W'(1);
            wmod_d     = wmod_wrap ? '0 : (wmod_q + WMOD_W'(1));
          end
        end
        S_INIT: begin
          state_d     = S_ROUND;
          round_idx_d = RIDX_W'(1);
        end
        S_ROUND: begin
          round_idx_d = round_idx_q + RIDX_W'(1);
          if (round_idx_q == (nr_q - RIDX_W'(1))) state_d = S_FINAL;
        end
        S_FINAL: begin
          state_d     = S_DONE;
          round_idx_d = '0;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    // Output strobes are registered copies of the decoded next state
    ready_d       = (state_d == S_IDLE);
    busy_d        = (state_d != S_IDLE);
    done_d        = (state_d == S_DONE);
    kexp_en_d     = (state_d == S_KEY_EXP);
    kexp_rot_d    = kexp_en_d && (wmod_d == '0);
    kexp_sub_d    = kexp_en_d && (nk_d == NK_W'(8)) && (wmod_d == WMOD_W'(4));
    ark_load_d    = (state_d == S_INIT);
    round_en_d    = (state_d == S_ROUND) || (state_d == S_FINAL);
    final_round_d = (state_d == S_FINAL);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      nk_q          <= '0;
      nr_q          <= '0;
      wmod_q        <= '0;
      cache_vld_q   <= 1'b0;
      cache_nk_q    <= '0;
      ready_q       <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      kexp_en_q     <= 1'b0;
      kexp_idx_q    <= '0;
      kexp_rot_q    <= 1'b0;
      kexp_sub_q    <= 1'b0;
      ark_load_q    <= 1'b0;
      round_en_q    <= 1'b0;
      final_round_q <= 1'b0;
      round_idx_q   <= '0;
    end else begin
      state_q       <= state_d;
      nk_q          <= nk_d;
      nr_q          <= nr_d;
      wmod_q        <= wmod_d;
      cache_vld_q   <= cache_vld_d;
      cache_nk_q    <= cache_nk_d;
      ready_q       <= ready_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
      kexp_en_q     <= kexp_en_d;
      kexp_idx_q    <= kexp_idx_d;
      kexp_rot_q    <= kexp_rot_d;
      kexp_sub_q    <= kexp_sub_d;
      ark_load_q    <= ark_load_d;
      round_en_q    <= round_en_d;
      final_round_q <= final_round_d;
      round_idx_q   <= round_idx_d;
    end
  end

  assign bus.ready       = ready_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.kexp_en     = kexp_en_q;
  assign bus.kexp_idx    = kexp_idx_q;
  assign bus.kexp_rot    = kexp_rot_q;
  assign bus.kexp_sub    = kexp_sub_q;
  assign bus.ark_load    = ark_load_q;
  assign bus.round_en    = round_en_q;
  assign bus.final_round = final_round_q;
  assign bus.round_idx   = round_idx_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench for aes_round_sequencer: latency table, directed corner sequences,
// and randomized blocks checked cycle-by-cycle against a trace-building reference model.
module tb_aes_round_sequencer;

  localparam int unsigned KLEN_W = 8;
  localparam int unsigned WIDX_W = 6;
  localparam int NV = 12;

  typedef struct packed {
    logic              ready;
    logic              busy;
    logic              done;
    logic              err;
    logic              kexp_en;
    logic [WIDX_W-1:0] kexp_idx;
    logic              kexp_rot;
    logic              kexp_sub;
    logic              ark_load;
    logic              round_en;
    logic              final_round;
    logic [3:0]        round_idx;
  } obs_t;

  typedef struct {
    logic [7:0] key_len;
    logic       new_key;
    int         exp_err;
    int         exp_kexp;
    int         exp_lat;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   m_vld;
  int   m_nk;

  aes_round_sequencer_if #(.KLEN_W(KLEN_W), .WIDX_W(WIDX_W)) bus ();

  aes_round_sequencer #(.KLEN_W(KLEN_W), .WIDX_W(WIDX_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.ready       = bus.ready;
    o.busy        = bus.busy;
    o.done        = bus.done;
    o.err         = bus.err;
    o.kexp_en     = bus.kexp_en;
    o.kexp_idx    = bus.kexp_idx;
    o.kexp_rot    = bus.kexp_rot;
    o.kexp_sub    = bus.kexp_sub;
    o.ark_load    = bus.ark_load;
    o.round_en    = bus.round_en;
    o.final_round = bus.final_round;
    o.round_idx   = bus.round_idx;
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("rdy=%0b bsy=%0b dn=%0b err=%0b ke=%0b ki=%0d rot=%0b sub=%0b ark=%0b re=%0b fin=%0b ri=%0d",
                     o.ready, o.busy, o.done, o.err, o.kexp_en, o.kexp_idx, o.kexp_rot,
                     o.kexp_sub, o.ark_load, o.round_en, o.final_round, o.round_idx);
  endfunction

  function automatic obs_t idle_obs();
    obs_t o;
    o = '0;
    o.ready = 1'b1;
    return o;
  endfunction

  task automatic check(input string name, input obs_t exp);
    obs_t act;
    act = sample();
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {%s} expected {%s}", name, fmt(act), fmt(exp));
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit decode(input logic [7:0] kl, output int nk, output int nr);
    nk = 0;
    nr = 0;
    case (kl)
      8'd16:   begin nk = 4; nr = 10; end
      8'd24:   begin nk = 6; nr = 12; end
      8'd32:   begin nk = 8; nr = 14; end
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  function automatic logic [7:0] pick_legal();
    int s;
    s = int'($urandom_range(0, 2));
    return (s == 0) ? 8'd16 : (s == 1) ? 8'd24 : 8'd32;
  endfunction

  // Start one block, build its expected cycle trace from the key-schedule rules, and compare.
  task automatic do_block(input logic [7:0] klen, input logic nkey, input int abort_at,
                          input bit glitch, input string tag);
    obs_t q[$];
    obs_t o;
    int   nk, nr, exp_len;
    bit   legal, expand, aborted;
    legal = decode(klen, nk, nr);
    bus.key_len = klen;
    bus.new_key = nkey;
    bus.start   = 1'b1;
    step();
    bus.start = 1'b0;
    if (!legal) begin
      o = idle_obs();
      o.err = 1'b1;
      check({tag, "_err"}, o);
      step();
      check({tag, "_err_idle"}, idle_obs());
      return;
    end
    expand  = nkey || !m_vld || (m_nk != nk);
    exp_len = expand ? (4 * (nr + 1) - nk) : 0;
    if (expand) begin
      for (int w = nk; w < 4 * (nr + 1); w++) begin
        o = '0;
        o.busy     = 1'b1;
        o.kexp_en  = 1'b1;
        o.kexp_idx = WIDX_W'(w);
        o.kexp_rot = ((w % nk) == 0);
        o.kexp_sub = (nk == 8) && ((w % 8) == 4);
        q.push_back(o);
      end
    end
    o = '0;
    o.busy     = 1'b1;
    o.ark_load = 1'b1;
    q.push_back(o);
    for (int r = 1; r <= nr; r++) begin
      o = '0;
      o.busy        = 1'b1;
      o.round_en    = 1'b1;
      o.final_round = (r == nr);
      o.round_idx   = 4'(r);
      q.push_back(o);
    end
    o = '0;
    o.busy = 1'b1;
    o.done = 1'b1;
    q.push_back(o);

    aborted = 1'b0;
    for (int i = 0; i < int'(q.size()); i++) begin
      check($sformatf("%s_c%0d", tag, i + 1), q[i]);
      if (i == abort_at) begin
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        aborted = 1'b1;
        break;
      end
      if (glitch && ($urandom_range(0, 3) == 0)) begin
        bus.start   = 1'b1;
        bus.key_len = pick_legal();
        bus.new_key = 1'($urandom_range(0, 1));
      end
      step();
      bus.start = 1'b0;
    end
    check({tag, aborted ? "_abort_idle" : "_end_idle"}, idle_obs());
    if (expand) begin
      if (aborted && (abort_at < exp_len)) m_vld = 1'b0;
      else begin
        m_vld = 1'b1;
        m_nk  = nk;
      end
    end
  endtask

  initial begin
    vec_t vecs [NV];
    obs_t o;
    int   c, kc, ec, lat;
    int   sel, gap;
    logic [7:0] kl, last_kl;
    logic nk_bit;
    int   ab;

    vecs[0]  = '{8'd16,  1'b0, 0, 40, 52};
    vecs[1]  = '{8'd16,  1'b0, 0,  0, 12};
    vecs[2]  = '{8'd32,  1'b0, 0, 52, 68};
    vecs[3]  = '{8'd20,  1'b0, 1,  0,  0};
    vecs[4]  = '{8'd32,  1'b0, 0,  0, 16};
    vecs[5]  = '{8'd24,  1'b0, 0, 46, 60};
    vecs[6]  = '{8'd24,  1'b1, 0, 46, 60};
    vecs[7]  = '{8'd0,   1'b0, 1,  0,  0};
    vecs[8]  = '{8'd16,  1'b1, 0, 40, 52};
    vecs[9]  = '{8'd16,  1'b0, 0,  0, 12};
    vecs[10] = '{8'd255, 1'b1, 1,  0,  0};
    vecs[11] = '{8'd16,  1'b0, 0,  0, 12};

    reset       = 1'b0;
    bus.start   = 1'b0;
    bus.new_key = 1'b0;
    bus.key_len = '0;
    bus.abort   = 1'b0;
    m_vld       = 1'b0;
    m_nk        = 0;
    repeat (3) step();
    check("reset_state", idle_obs());
    reset = 1'b1;
    step();
    check("after_release", idle_obs());

    // Latency / expansion-length table
    for (int r = 0; r < NV; r++) begin
      bus.key_len = vecs[r].key_len;
      bus.new_key = vecs[r].new_key;
      bus.start   = 1'b1;
      step();
      bus.start = 1'b0;
      c = 1; kc = 0; ec = 0; lat = 0;
      forever begin
        if (bus.kexp_en) kc++;
        if (bus.err) ec++;
        if (bus.done) begin lat = c; break; end
        if (bus.ready && (c >= 2)) break;
        if (c >= 100) break;
        step();
        c++;
      end
      check_int($sformatf("vec%0d_err", r), ec, vecs[r].exp_err);
      check_int($sformatf("vec%0d_kexp", r), kc, vecs[r].exp_kexp);
      check_int($sformatf("vec%0d_lat", r), lat, vecs[r].exp_lat);
      if (lat != 0) step();
    end
    m_vld = 1'b1;
    m_nk  = 4;

    // Start held high through DONE is taken one cycle later, from IDLE
    bus.key_len = 8'd16;
    bus.new_key = 1'b0;
    bus.start   = 1'b1;
    step();
    c = 1;
    while (!bus.done && c < 30) begin step(); c++; end
    check_int("held_lat", c, 12);
    step();
    check("held_idle", idle_obs());
    step();
    o = '0;
    o.busy = 1'b1;
    o.ark_load = 1'b1;
    check("held_reaccept", o);
    bus.start = 1'b0;
    c = 1;
    while (!bus.done && c < 30) begin step(); c++; end
    check_int("held_lat2", c, 12);
    step();
    check("held_end_idle", idle_obs());

    do_block(8'd32, 1'b0, -1, 1'b0, "k32");
    do_block(8'd24, 1'b1, 24, 1'b0, "abort_kexp30");
    do_block(8'd24, 1'b0, -1, 1'b0, "reexp24");
    do_block(8'd20, 1'b0, -1, 1'b0, "illegal20");
    do_block(8'd24, 1'b0, -1, 1'b0, "cached24");
    do_block(8'd24, 1'b0, 5, 1'b0, "abort_round");
    do_block(8'd24, 1'b0, -1, 1'b0, "cached24b");

    // Asynchronous reset mid-ROUND
    bus.key_len = 8'd16;
    bus.new_key = 1'b0;
    bus.start   = 1'b1;
    step();
    bus.start = 1'b0;
    c = 0;
    while ((bus.round_idx != 4'd5) && (c < 120)) begin step(); c++; end
    check_int("rst_reach_r5", int'(bus.round_idx), 5);
    #2 reset = 1'b0;
    #1 check("rst_async", idle_obs());
    step();
    check("rst_hold", idle_obs());
    reset = 1'b1;
    m_vld = 1'b0;
    step();
    check("rst_release", idle_obs());
    do_block(8'd16, 1'b0, -1, 1'b0, "post_rst");

    // Randomized blocks
    last_kl = 8'd16;
    for (int it = 0; it < 25; it++) begin
      sel = int'($urandom_range(0, 9));
      if (sel <= 2) kl = 8'd16;
      else if (sel <= 4) kl = 8'd24;
      else if (sel <= 6) kl = 8'd32;
      else if (sel == 7) begin
        kl = 8'($urandom_range(0, 255));
        if (kl == 8'd16 || kl == 8'd24 || kl == 8'd32) kl = kl + 8'd1;
      end else kl = last_kl;
      if (sel != 7) last_kl = kl;
      nk_bit = ($urandom_range(0, 4) == 0);
      ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 60)) : -1;
      do_block(kl, nk_bit, ab, 1'b1, $sformatf("rnd%0d", it));
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        bus.abort = 1'($urandom_range(0, 1));
        step();
        bus.abort = 1'b0;
        check($sformatf("rnd%0d_gap%0d", it, g), idle_obs());
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
- Controls one shared iterative AES round datapath and its word-serial key expander. It replaces the three parallel unrolled cipher instances with a single round unit that is sequenced over Nr rounds.
- Sits between the SPI-slave driver (start/done handshake, key-length byte 16/24/32) and the round/key-expansion datapath.
- Caches the expanded key, so back-to-back blocks under the same key skip key expansion.

Parameters:
- KLEN_W, 8, width of the key-length byte; legal values are 16, 24 and 32.
- WIDX_W, 6, width of the key-word index (covers words 0..59).

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request to process one block; accepted only when ready=1.
- new_key  input  1  sampled with an accepted start; 1 forces key re-expansion.
- key_len  input  KLEN_W  key length in bytes, sampled with an accepted start.
- abort  input  1  cancels any operation in progress.
- ready  output  1  high in IDLE.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when the block result is valid on the datapath.
- err  output  1  one-cycle pulse when start is given with an illegal key_len.
- kexp_en  output  1  key expander computes word kexp_idx this cycle.
- kexp_idx  output  WIDX_W  index of the expanded-key word being generated.
- kexp_rot  output  1  kexp_idx mod Nk == 0: apply RotWord, SubWord and Rcon.
- kexp_sub  output  1  Nk==8 and kexp_idx mod 8 == 4: apply SubWord only.
- ark_load  output  1  load state register with input XOR round key 0.
- round_en  output  1  round datapath advances this cycle.
- final_round  output  1  current round omits MixColumns.
- round_idx  output  4  round-key index used this cycle.

Behaviour:
- Key-length decode: key_len 16 -> Nk=4, Nr=10; 24 -> Nk=6, Nr=12; 32 -> Nk=8, Nr=14. Any other value is illegal.
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0 except ready=1.
  - Cached-key valid flag and cached Nk are cleared.
- States: IDLE, KEY_EXP, INIT, ROUND, FINAL, DONE.
- IDLE:
  - start with an illegal key_len: err=1 for the next cycle, state stays IDLE, cache is untouched.
  - start with a legal key_len: latch Nk and Nr.
  - Go to KEY_EXP if new_key=1, or the cache is invalid, or the latched Nk differs from the cached Nk. Otherwise go to INIT.
- KEY_EXP:
  - kexp_en=1; kexp_idx steps Nk, Nk+1, ..., 4*(Nr+1)-1, one word per cycle.
  - kexp_rot and kexp_sub are valid in the same cycle as the kexp_idx they qualify.
  - The cycle after the last word, the cache is marked valid with Nk and the state goes to INIT.
  - Duration is 40, 46 or 52 cycles for Nk = 4, 6 or 8.
- INIT: one cycle; ark_load=1, round_idx=0.
- ROUND: round_en=1; round_idx runs 1..Nr-1, one per cycle; then go to FINAL.
- FINAL: one cycle; round_en=1, final_round=1, round_idx=Nr.
- DONE: one cycle; done=1; then return to IDLE.
- Latency with a cached key: start accepted at edge t, done is high in cycle t+Nr+2 (12, 14 or 16 cycles).
- Latency with key expansion: add the KEY_EXP duration to the cached-key latency.
- Start outside IDLE: ignored; no queueing.
- A start held high in the DONE cycle is not accepted. It is accepted one cycle later, in IDLE.
- abort: has priority over all transitions. Next state is IDLE and no done is generated.
  - Abort during KEY_EXP invalidates the cache.
  - Abort during any other state leaves the cache valid.
- Strobes: done, err, ark_load and kexp_en are never high in the same cycle.
- Idle output values: round_idx and kexp_idx hold 0 when not in their active states.

Test Plan:
- Cold start, key_len=16, new_key=0 after reset: 40 kexp_en cycles (idx 4..43), kexp_rot at idx 4, 8, ..., 40. Then INIT, rounds 1..10 with final_round only at 10; done at start+52.
- Immediate second start, key_len=16, new_key=0: no KEY_EXP; ark_load at start+1; done at start+12; busy high for 12 cycles.
- key_len=32 after a cached 16-byte key: re-expansion over idx 8..59. kexp_rot at 8, 16, ..., 56; kexp_sub at 12, 20, ..., 52. done after 52+16 cycles.
- key_len=20 with start: err pulse in the next cycle, ready stays 1, no kexp_en/round_en. A following cached 16-byte start still skips KEY_EXP.
- abort during KEY_EXP at idx 30 (key_len=24): IDLE next cycle, no done. Next start with new_key=0 re-expands idx 6..51.
- reset driven low mid-ROUND (round_idx=5): outputs clear immediately without a clock edge, ready=1. The next start performs full expansion.
